mips_boot_loader: RTL and testbench

//  Byte-stream program loader placed upstream of the 5-stage MIPS pipeline. It receives a framed

---
 rtl/mips_boot_loader.sv | 147 ++++++++++++++
 tb/tb_mips_boot_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_boot_loader.sv
// Framed byte-stream loader for the MIPS unified Mem: assembles big-endian words,
// writes them, and releases the processor with a start pulse once the checksum passes.
module mips_boot_loader #(
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              cpu_start,
    output logic              load_done,
    output logic              load_err,
    output logic [15:0]       words_written
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ADDR_HI,
        ADDR_LO,
        CNT_HI,
        CNT_LO,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    state_t            state;
    logic [7:0]        addr_hi_q;
    logic [7:0]        cnt_hi_q;
    logic [ADDR_W-1:0] cur_addr;
    logic [17:0]       bytes_left;
    logic [1:0]        byte_idx;
    logic [23:0]       asm_q;
    logic [7:0]        csum_q;
    logic [IDLE_W-1:0] idle_q;

    logic accept;
    logic timing;
    logic idle_hit;

    assign accept   = in_valid & in_ready;
    assign timing   = state inside {ADDR_LO, CNT_HI, CNT_LO, DATA, CSUM};
    assign idle_hit = timing && !accept && (idle_q == IDLE_LAST);

    always_ff @(posedge clk1) begin
        if (reset) begin
            state         <= ADDR_HI;
            addr_hi_q     <= '0;
            cnt_hi_q      <= '0;
            cur_addr      <= '0;
            bytes_left    <= '0;
            byte_idx      <= '0;
            asm_q         <= '0;
            csum_q        <= '0;
            idle_q        <= '0;
            in_ready      <= 1'b1;
            mem_wr_en     <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            cpu_hold      <= 1'b1;
            cpu_start     <= 1'b0;
            load_done     <= 1'b0;
            load_err      <= 1'b0;
            words_written <= '0;
        end else begin
            in_ready  <= 1'b1;
            mem_wr_en <= 1'b0;
            cpu_start <= 1'b0;
            if (idle_hit) begin
                // Abandon the frame; any partial word stays unwritten.
                state    <= ERR;
                load_err <= 1'b1;
                idle_q   <= '0;
            end else if (accept) begin
                idle_q <= '0;
                unique case (state)
                    ADDR_HI, DONE, ERR: begin
                        addr_hi_q     <= in_data;
                        cpu_hold      <= 1'b1;
                        load_done     <= 1'b0;
                        load_err      <= 1'b0;
                        words_written <= '0;
                        state         <= ADDR_LO;
                    end
                    ADDR_LO: begin
                        cur_addr <= ADDR_W'({addr_hi_q, in_data});
                        state    <= CNT_HI;
                    end
                    CNT_HI: begin
                        cnt_hi_q <= in_data;
                        state    <= CNT_LO;
                    end
                    CNT_LO: begin
                        bytes_left <= {cnt_hi_q, in_data, 2'b00};
                        byte_idx   <= '0;
                        csum_q     <= '0;
                        if ({cnt_hi_q, in_data} == 16'd0)
                            state <= CSUM;
                        else
                            state <= DATA;
                    end
                    DATA: begin
                        csum_q     <= csum_q ^ in_data;
                        bytes_left <= bytes_left - 18'd1;
                        byte_idx   <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            // Write port is separate so the next word can assemble now.
                            mem_wr_en     <= 1'b1;
                            mem_addr      <= cur_addr;
                            mem_wdata     <= {asm_q, in_data};
                            cur_addr      <= cur_addr + ADDR_W'(1);
                            words_written <= words_written + 16'd1;
                        end else begin
                            asm_q <= {asm_q[15:0], in_data};
                        end
                        if (bytes_left == 18'd1)
                            state <= CSUM;
                    end
                    CSUM: begin
                        if (in_data == csum_q) begin
                            state     <= DONE;
                            cpu_start <= 1'b1;
                            cpu_hold  <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end
                    end
                    default: state <= ADDR_HI;
                endcase
            end else if (timing) begin
                idle_q <= idle_q + IDLE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mips_boot_loader.sv
// Directed bench for mips_boot_loader: good/bad frames, wrap, empty frame,
// timeout and mid-frame reset, all checked against hand-computed values.
module tb_mips_boot_loader;

    logic        clk1;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_wr_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        cpu_start;
    logic        load_done;
    logic        load_err;
    logic [15:0] words_written;

    mips_boot_loader #(
        .ADDR_W      (10),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk1          (clk1),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .mem_wr_en     (mem_wr_en),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .cpu_hold      (cpu_hold),
        .cpu_start     (cpu_start),
        .load_done     (load_done),
        .load_err      (load_err),
        .words_written (words_written)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int starts = 0;
    int hold_bad = 0;

    logic [9:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    logic [31:0] fw [8];

    always @(posedge clk1) cyc <= cyc + 1;

    always @(negedge clk1) begin
        if (mem_wr_en) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            wr_cyc_q.push_back(cyc);
        end
        if (cpu_start) begin
            starts++;
            if (cpu_hold) hold_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        starts   = 0;
        hold_bad = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk1);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] a, input logic [15:0] n,
                              input logic [7:0] flip);
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        send_byte(n[15:8]);
        send_byte(n[7:0]);
        for (int i = 0; i < int'(n); i++) begin
            for (int j = 3; j >= 0; j--) begin
                b = fw[i][8*j +: 8];
                cs = cs ^ b;
                send_byte(b);
            end
        end
        send_byte(cs ^ flip);
        in_valid = 1'b0;
        repeat (3) @(posedge clk1);
        #1;
    endtask

    task automatic chk_writes(input string tag, input logic [9:0] base,
                              input int n);
        logic [9:0] ea;
        chk({tag, "_nwr"}, wr_addr_q.size(), n);
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            ea = base + 10'(i);
            chk($sformatf("%s_addr%0d", tag, i), 32'(wr_addr_q[i]), 32'(ea));
            chk($sformatf("%s_data%0d", tag, i), wr_data_q[i], fw[i]);
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk1);
        #1;
        reset = 1'b0;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_wr", 32'(mem_wr_en), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_start", 32'(cpu_start), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        chk("rst_ww", 32'(words_written), 32'd0);

        fw[0] = 32'h28010078; fw[1] = 32'h0c631800;
        fw[2] = 32'h20220000; fw[3] = 32'h0c631800;
        fw[4] = 32'h2842002d; fw[5] = 32'h0c631800;
        fw[6] = 32'h24220001; fw[7] = 32'hfc000000;

        clear_mon();
        send_frame(16'h0000, 16'd8, 8'h00);
        chk_writes("t1", 10'h000, 8);
        chk("t1_ww", 32'(words_written), 32'd8);
        chk("t1_starts", starts, 1);
        chk("t1_hold_at_start", hold_bad, 0);
        chk("t1_hold", 32'(cpu_hold), 32'd0);
        chk("t1_done", 32'(load_done), 32'd1);
        chk("t1_err", 32'(load_err), 32'd0);
        chk("t1_start_low", 32'(cpu_start), 32'd0);

        clear_mon();
        send_frame(16'h0000, 16'd8, 8'h01);
        chk_writes("t2", 10'h000, 8);
        chk("t2_err", 32'(load_err), 32'd1);
        chk("t2_done", 32'(load_done), 32'd0);
        chk("t2_hold", 32'(cpu_hold), 32'd1);
        chk("t2_starts", starts, 0);

        clear_mon();
        fw[0] = 32'h11223344;
        fw[1] = 32'ha5b6c7d8;
        send_frame(16'h03ff, 16'd2, 8'h00);
        chk("t3_nwr", wr_addr_q.size(), 2);
        if (wr_addr_q.size() == 2) begin
            chk("t3_addr0", 32'(wr_addr_q[0]), 32'h3ff);
            chk("t3_addr1", 32'(wr_addr_q[1]), 32'h000);
            chk("t3_data1", wr_data_q[1], 32'ha5b6c7d8);
        end
        chk("t3_done", 32'(load_done), 32'd1);

        clear_mon();
        fw[0] = 32'h0badf00d;
        send_frame(16'hfc01, 16'd1, 8'h00);
        chk_writes("t3b", 10'h001, 1);

        clear_mon();
        send_frame(16'h0040, 16'd0, 8'h00);
        chk("t4_nwr", wr_addr_q.size(), 0);
        chk("t4_starts", starts, 1);
        chk("t4_done", 32'(load_done), 32'd1);
        chk("t4_hold", 32'(cpu_hold), 32'd0);
        chk("t4_ww", 32'(words_written), 32'd0);

        clear_mon();
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hde);
        send_byte(8'had);
        in_valid = 1'b0;
        repeat (15) @(posedge clk1);
        #1;
        chk("t5_err_early", 32'(load_err), 32'd0);
        @(posedge clk1);
        #1;
        chk("t5_err", 32'(load_err), 32'd1);
        chk("t5_nwr", wr_addr_q.size(), 0);
        chk("t5_hold", 32'(cpu_hold), 32'd1);
        chk("t5_starts", starts, 0);
        fw[0] = 32'hcafef00d;
        send_frame(16'h0010, 16'd1, 8'h00);
        chk_writes("t5g", 10'h010, 1);
        chk("t5g_done", 32'(load_done), 32'd1);
        chk("t5g_err", 32'(load_err), 32'd0);

        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h04);
        for (int k = 0; k < 5; k++) send_byte(8'h55);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hab;
        @(posedge clk1);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("t6_hold", 32'(cpu_hold), 32'd1);
        chk("t6_done", 32'(load_done), 32'd0);
        chk("t6_ww", 32'(words_written), 32'd0);
        chk("t6_wr", 32'(mem_wr_en), 32'd0);
        clear_mon();
        fw[0] = 32'h01020304; fw[1] = 32'h05060708;
        fw[2] = 32'h090a0b0c; fw[3] = 32'h0d0e0f10;
        send_frame(16'h0200, 16'd4, 8'h00);
        chk_writes("t6", 10'h200, 4);
        for (int i = 1; i < wr_cyc_q.size(); i++)
            chk($sformatf("t6_gap%0d", i), wr_cyc_q[i] - wr_cyc_q[i-1], 4);
        chk("t6_ww_end", 32'(words_written), 32'd4);
        chk("t6_done_end", 32'(load_done), 32'd1);
        chk("t6_starts", starts, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
